// File: rtl/bcd_word_display_rx.sv
// bcd_word_display_rx: receives the BCD counter's two-word bus, filters it
// for stability, validates tags and nibbles, latches the accepted digits and
// scans them onto a common-anode 4-digit 7-segment display with leading-zero
// blanking and a one-cycle all-anodes-off gap between digit slots.
module bcd_word_display_rx #(
   parameter int unsigned F_CLK_HZ       = 25_000_000,
   parameter int unsigned SCAN_HZ        = 1000,
   parameter bit          SEG_ACTIVE_LOW = 1'b1,
   parameter bit          AN_ACTIVE_LOW  = 1'b1,
   parameter bit          BLANK_LEADING  = 1'b1,
   parameter logic [3:0]  DP_MASK        = 4'b0000
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [8:0]  word_lo,
   input  logic [8:0]  word_hi,
   output logic [15:0] digits,
   output logic        update,
   output logic        frame_err,
   output logic [6:0]  seg,
   output logic        dp,
   output logic [3:0]  an
);

   localparam int unsigned SCAN_DIV = F_CLK_HZ / SCAN_HZ;
   localparam int unsigned SCAN_TKS = (SCAN_DIV < 1) ? 1 : SCAN_DIV;
   localparam int unsigned CNT_W    = (SCAN_TKS > 1) ? $clog2(SCAN_TKS) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_TKS - 1);

   localparam logic [6:0]  SEG_OFF  = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
   localparam logic [3:0]  AN_OFF   = AN_ACTIVE_LOW ? 4'hF : 4'h0;
   localparam logic        DP_OFF   = SEG_ACTIVE_LOW;
   // Pipeline reset value is {hi, lo} = {9'h100, 9'h000}: a valid all-zero frame.
   localparam logic [17:0] PIPE_RST = {9'h100, 9'h000};

   // Active-high segment pattern for a BCD digit; codes above 9 are filtered
   // at accept and never get here, so they simply map to all-off.
   function automatic logic [6:0] seg7(input logic [3:0] n);
      logic [6:0] s;
      case (n)
         4'd0:    s = 7'h3F;
         4'd1:    s = 7'h06;
         4'd2:    s = 7'h5B;
         4'd3:    s = 7'h4F;
         4'd4:    s = 7'h66;
         4'd5:    s = 7'h6D;
         4'd6:    s = 7'h7D;
         4'd7:    s = 7'h07;
         4'd8:    s = 7'h7F;
         4'd9:    s = 7'h6F;
         default: s = 7'h00;
      endcase
      return s;
   endfunction

   // ---------------------------------------------------------------- input path
   logic [17:0] q1_q, q2_q;
   logic [15:0] digits_q, digits_d;
   logic        update_q, update_d;
   logic        ferr_q, ferr_d;

   logic [8:0]  lo2, hi2;
   logic [15:0] frame_nibs;
   logic        stable, valid;

   assign lo2        = q2_q[8:0];
   assign hi2        = q2_q[17:9];
   assign frame_nibs = {hi2[7:0], lo2[7:0]};
   assign stable     = (q1_q == q2_q);
   assign valid      = !lo2[8] && hi2[8] &&
                       (frame_nibs[15:12] <= 4'd9) && (frame_nibs[11:8] <= 4'd9) &&
                       (frame_nibs[7:4]   <= 4'd9) && (frame_nibs[3:0]  <= 4'd9);

   // Accept rule: only a stable frame can change digits or the error flag.
   always_comb begin
      digits_d = digits_q;
      update_d = 1'b0;
      ferr_d   = ferr_q;
      if (stable) begin
         if (valid) begin
            ferr_d = 1'b0;
            if (frame_nibs != digits_q) begin
               digits_d = frame_nibs;
               update_d = 1'b1;
            end
         end else begin
            ferr_d = 1'b1;
         end
      end
   end

   // Two-stage input capture plus the accepted-value registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         q1_q     <= PIPE_RST;
         q2_q     <= PIPE_RST;
         digits_q <= '0;
         update_q <= 1'b0;
         ferr_q   <= 1'b0;
      end else begin
         q1_q     <= {word_hi, word_lo};
         q2_q     <= q1_q;
         digits_q <= digits_d;
         update_q <= update_d;
         ferr_q   <= ferr_d;
      end
   end

   // ---------------------------------------------------------------- display scan
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]       idx_q, idx_d;
   logic [3:0]       an_q, an_d;
   logic [6:0]       seg_q, seg_d;
   logic             dp_q, dp_d;

   logic             scan_tick;
   logic [3:0]       cur_nib;
   logic             blank_m, blank_c, blank_d, cur_blank;
   logic [3:0]       an_ah;
   logic [6:0]       seg_ah;

   assign scan_tick = (cnt_q == CNT_LAST);
   assign cur_nib   = digits_q[{idx_q, 2'b00} +: 4];
   assign blank_m   = BLANK_LEADING && (digits_q[15:12] == 4'd0);
   assign blank_c   = blank_m && (digits_q[11:8] == 4'd0);
   assign blank_d   = blank_c && (digits_q[7:4] == 4'd0);

   // Next scan state. The tick cycle forces every anode off (the ghost gap);
   // the following cycle enables the new slot and loads seg/dp together, and
   // the slot keeps re-reading digits so a mid-slot update shows one cycle later.
   always_comb begin
      cnt_d     = scan_tick ? '0 : cnt_q + 1'b1;
      idx_d     = idx_q;
      an_d      = AN_OFF;
      seg_d     = seg_q;
      dp_d      = dp_q;
      an_ah     = '0;
      seg_ah    = '0;
      case (idx_q)
         2'd3:    cur_blank = blank_m;
         2'd2:    cur_blank = blank_c;
         2'd1:    cur_blank = blank_d;
         default: cur_blank = 1'b0;
      endcase
      if (scan_tick) begin
         idx_d = idx_q + 2'd1;
         an_d  = AN_OFF;
      end else begin
         an_ah  = cur_blank ? 4'b0000 : (4'b0001 << idx_q);
         seg_ah = cur_blank ? 7'h00 : seg7(cur_nib);
         an_d   = AN_ACTIVE_LOW ? ~an_ah : an_ah;
         seg_d  = SEG_ACTIVE_LOW ? ~seg_ah : seg_ah;
         dp_d   = SEG_ACTIVE_LOW ? ~DP_MASK[idx_q] : DP_MASK[idx_q];
      end
   end

   // Scan registers; outputs are driven straight from these, so reset blanks
   // the display asynchronously without passing through an active anode.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q <= '0;
         idx_q <= 2'd0;
         an_q  <= AN_OFF;
         seg_q <= SEG_OFF;
         dp_q  <= DP_OFF;
      end else begin
         cnt_q <= cnt_d;
         idx_q <= idx_d;
         an_q  <= an_d;
         seg_q <= seg_d;
         dp_q  <= dp_d;
      end
   end

   assign digits    = digits_q;
   assign update    = update_q;
   assign frame_err = ferr_q;
   assign seg       = seg_q;
   assign dp        = dp_q;
   assign an        = an_q;

endmodule

// File: tb/tb_bcd_word_display_rx.sv
// Directed testbench for bcd_word_display_rx with a 4-cycle scan slot
// (F_CLK_HZ=16, SCAN_HZ=4), active-low seg/an, leading-zero blanking on.
module tb_bcd_word_display_rx;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [8:0]  word_lo, word_hi;
   logic [15:0] digits;
   logic        update, frame_err;
   logic [6:0]  seg;
   logic        dp;
   logic [3:0]  an;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc;

   bcd_word_display_rx #(
      .F_CLK_HZ      (16),
      .SCAN_HZ       (4),
      .SEG_ACTIVE_LOW(1'b1),
      .AN_ACTIVE_LOW (1'b1),
      .BLANK_LEADING (1'b1),
      .DP_MASK       (4'b0000)
   ) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .word_lo  (word_lo),
      .word_hi  (word_hi),
      .digits   (digits),
      .update   (update),
      .frame_err(frame_err),
      .seg      (seg),
      .dp       (dp),
      .an       (an)
   );

   always #5 clk = ~clk;

   // Rising edges since the last reset release; edge k has k%4==0 as the ghost cycle.
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) cyc <= 0;
      else          cyc <= cyc + 1;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [8:0] lo, input logic [8:0] hi);
      @(negedge clk);
      word_lo = lo;
      word_hi = hi;
   endtask

   function automatic logic [6:0] enc(input logic [3:0] n);
      logic [6:0] t [10];
      t = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
      return (n <= 4'd9) ? t[n] : 7'h00;
   endfunction

   // Check n consecutive cycles of the scan against a steady accepted value.
   task automatic check_scan(input logic [15:0] val, input int n);
      int         k, idx;
      logic [3:0] nib, an_e;
      logic [6:0] seg_e;
      logic       bl;
      for (int i = 0; i < n; i++) begin
         tick();
         k = cyc;
         chk("scan_digits", digits, val);
         chk("scan_update", update, 0);
         chk("an_onehot", ($countones(~an) <= 1), 1);
         if (k % 4 == 0) begin
            chk("an_ghost", an, 4'hF);
         end else begin
            idx = (k / 4) % 4;
            nib = val[idx*4 +: 4];
            bl  = (idx == 3 && val[15:12] == 0) ||
                  (idx == 2 && val[15:8] == 0) ||
                  (idx == 1 && val[15:4] == 0);
            an_e  = bl ? 4'hF : ~(4'b0001 << idx);
            seg_e = bl ? 7'h7F : ~enc(nib);
            chk("scan_an", an, an_e);
            chk("scan_seg", seg, seg_e);
            chk("scan_dp", dp, 1);
         end
      end
   endtask

   initial begin
      reset_n = 1'b0;
      word_lo = 9'h000;
      word_hi = 9'h100;

      // Reset state
      repeat (3) tick();
      chk("rst_digits", digits, 16'h0000);
      chk("rst_update", update, 0);
      chk("rst_ferr", frame_err, 0);
      chk("rst_an", an, 4'hF);
      chk("rst_seg", seg, 7'h7F);
      chk("rst_dp", dp, 1);

      // Release: zero frame, only U lit with "0"
      @(negedge clk);
      reset_n = 1'b1;
      chk("ferr_after_rel", frame_err, 0);
      check_scan(16'h0000, 16);

      // Accept 0159 two cycles after the change
      drive(9'h059, 9'h101);
      tick(); chk("acc_e0_digits", digits, 16'h0000); chk("acc_e0_upd", update, 0);
      tick(); chk("acc_e1_digits", digits, 16'h0000); chk("acc_e1_upd", update, 0);
      tick(); chk("acc_e2_digits", digits, 16'h0159); chk("acc_e2_upd", update, 1);
      chk("acc_e2_ferr", frame_err, 0);
      tick(); chk("acc_e3_upd", update, 0);
      check_scan(16'h0159, 16);

      // Bad hi tag
      drive(9'h059, 9'h001);
      tick(); chk("tag_e0_ferr", frame_err, 0);
      tick(); chk("tag_e1_ferr", frame_err, 0);
      tick(); chk("tag_e2_ferr", frame_err, 1); chk("tag_e2_digits", digits, 16'h0159);
      chk("tag_e2_upd", update, 0);
      tick(); chk("tag_e3_ferr", frame_err, 1);

      // Restore same value: error clears, no update
      drive(9'h059, 9'h101);
      tick(); chk("fix_e0_ferr", frame_err, 1);
      tick(); chk("fix_e1_ferr", frame_err, 1);
      tick(); chk("fix_e2_ferr", frame_err, 0); chk("fix_e2_upd", update, 0);
      chk("fix_e2_digits", digits, 16'h0159);
      tick(); chk("fix_e3_upd", update, 0);

      // Non-BCD U nibble
      drive(9'h05A, 9'h101);
      tick(); chk("nib_e0_ferr", frame_err, 0);
      tick(); chk("nib_e1_ferr", frame_err, 0);
      tick(); chk("nib_e2_ferr", frame_err, 1); chk("nib_e2_digits", digits, 16'h0159);
      check_scan(16'h0159, 8);
      drive(9'h059, 9'h101);
      repeat (3) tick();
      chk("nib_fix_ferr", frame_err, 0);
      chk("nib_fix_upd", update, 0);

      // Word that changes every cycle is never accepted
      for (int i = 0; i < 20; i++) begin
         drive((i % 2) ? 9'h034 : 9'h012, 9'h101);
         tick();
         chk("tog_upd", update, 0);
         chk("tog_digits", digits, 16'h0159);
      end
      drive(9'h023, 9'h101);
      tick(); chk("hold_e0_upd", update, 0);
      tick(); chk("hold_e1_upd", update, 0);
      tick(); chk("hold_e2_upd", update, 1); chk("hold_e2_lo", digits[7:0], 8'h23);
      chk("hold_e2_digits", digits, 16'h0123);
      tick(); chk("hold_e3_upd", update, 0);

      // Asynchronous reset while an anode is lit
      for (int i = 0; i < 20; i++) begin
         tick();
         if (an != 4'hF) break;
      end
      chk("an_lit_before_rst", (an != 4'hF), 1);
      #2;
      reset_n = 1'b0;
      #1;
      chk("arst_an", an, 4'hF);
      chk("arst_seg", seg, 7'h7F);
      chk("arst_dp", dp, 1);
      chk("arst_digits", digits, 16'h0000);
      chk("arst_upd", update, 0);
      chk("arst_ferr", frame_err, 0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;

      // Restart on U showing 0, then the held 0123 frame is re-accepted
      tick(); chk("rr_p1_an", an, 4'hE); chk("rr_p1_seg", seg, 7'h40); chk("rr_p1_digits", digits, 16'h0000);
      tick(); chk("rr_p2_an", an, 4'hE); chk("rr_p2_seg", seg, 7'h40); chk("rr_p2_upd", update, 0);
      tick(); chk("rr_p3_digits", digits, 16'h0123); chk("rr_p3_upd", update, 1); chk("rr_p3_seg", seg, 7'h40);
      tick(); chk("rr_p4_an", an, 4'hF); chk("rr_p4_upd", update, 0);
      check_scan(16'h0123, 16);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/bcd_word_display_rx.md
Name: bcd_word_display_rx

Overview:
- Consumer end of the BCD counter's two-word output bus.
- The counter produces word_lo = {0, D, U} and word_hi = {1, M, C}, and this block takes that pair in.
- It filters the pair for stability, checks the tag bits and BCD nibbles, and latches the four accepted digits.
- It then drives a time-multiplexed common-anode 4-digit 7-segment display.
- It sits on the board top, directly fed by the counter in the same clock domain.

Parameters:
- F_CLK_HZ, 25_000_000: clock frequency in Hz.
- SCAN_HZ, 1000: per-digit scan rate in Hz. SCAN_TKS = max(1, F_CLK_HZ/SCAN_HZ).
- SEG_ACTIVE_LOW, 1: 1 means seg and dp are driven low to light.
- AN_ACTIVE_LOW, 1: 1 means an is driven low to enable a digit.
- BLANK_LEADING, 1: 1 means leading zeros are suppressed.
- DP_MASK, 4'b0000: dp is lit when DP_MASK[idx] is 1 (idx 0=U .. 3=M).

Ports:
- clk  in  1: system clock, all logic on rising edge.
- reset_n  in  1: asynchronous active-low reset; assertion is async, deassertion is taken as synchronous to clk upstream.
- word_lo  in  9: {tag=0, D[3:0], U[3:0]}.
- word_hi  in  9: {tag=1, M[3:0], C[3:0]}.
- digits  out  16: accepted value {M, C, D, U}.
- update  out  1: one-cycle pulse when digits changes.
- frame_err  out  1: high while the last stable frame was invalid.
- seg  out  7: segments {g,f,e,d,c,b,a}; seg[0]=a.
- dp  out  1: decimal point.
- an  out  4: digit enables; an[0]=U .. an[3]=M.

Behaviour:
Reset (reset_n=0, asynchronous):
- digits=16'h0000, update=0, frame_err=0.
- Input pipeline q1 = q2 = {lo=9'h000, hi=9'h100}.
- scan idx=0, prescaler=0, ghost flag=0.
- an, seg and dp all inactive (levels per polarity parameters).

Input path:
- q1 samples {word_hi, word_lo} every cycle; q2 <= q1.
- A frame is stable when q1 == q2.

Frame valid, all of:
- q2 lo[8]=0 and hi[8]=1.
- All four nibbles <= 9.

Accept rule (evaluated every cycle on a stable frame):
- Valid and nibbles differ from digits: digits <= frame nibbles, update=1 for exactly one cycle, frame_err <= 0.
- Valid and identical to digits: no change, update=0, frame_err <= 0.
- Invalid: digits held, frame_err <= 1.
- Not stable: nothing changes.

Latency:
- Input change applied before edge E0 → q1 at E0 → q2 at E1 → digits and update visible after E2. That is 2 cycles, then update drops after E3.
- A word pair that changes every cycle is never accepted.

Scan prescaler:
- Counts 0..SCAN_TKS-1 and wraps; scan_tick is high at SCAN_TKS-1.
- If SCAN_TKS=1, scan_tick is high every cycle.

On scan_tick (anti-ghosting):
- idx <= idx+1 mod 4.
- All anodes go inactive for exactly that one cycle (ghost flag set).
- On the next cycle the anode for the new idx is enabled and the ghost flag clears.
- seg and dp are registered and change in the same cycle as the anode enable.

Segment encoding (active-high before polarity inversion):

| Digit | seg (hex) |
|---|---|
| 0 | 3F |
| 1 | 06 |
| 2 | 5B |
| 3 | 4F |
| 4 | 66 |
| 5 | 6D |
| 6 | 7D |
| 7 | 07 |
| 8 | 7F |
| 9 | 6F |

Nibbles above 9 never reach the encoder because they are filtered at accept.

Leading-zero blanking (when BLANK_LEADING=1):
- M is blank if M=0.
- C is blank if M=0 and C=0.
- D is blank if M=0, C=0 and D=0.
- U is never blanked.
- For a blank digit, its anode stays inactive for the whole slot and seg is all-off; dp still follows DP_MASK but is invisible.

Digit source:
- The displayed digit always comes from digits, read at the time of the slot's enable cycle.
- A mid-slot update changes seg on the next cycle for the current idx.

Reset mid-operation:
- All outputs go to reset values immediately, with no glitch through an active anode.
- After release, scan restarts at idx=0 (U) and the display shows "0" on U only.

Test Plan:
- Reset release, inputs lo=000, hi=100 → digits=0000, update never pulses, frame_err=0. With F_CLK_HZ=16, SCAN_HZ=4: an = U, off, D-slot inactive (blanked), … with U showing seg=3F.
- Step word_lo to {0,4'h5,4'h9}, word_hi to {1,4'h0,4'h1} and hold → digits=16'h0159 exactly 2 cycles after the change, update high for 1 cycle. Scan shows U=6F, D=6D, C=06, and M's anode stays inactive.
- Apply hi tag=0 (hi=9'h001) stably → frame_err=1 after 2 cycles, digits held at previous value. Restore hi=9'h101 → frame_err=0, update pulses only if the value differs.
- Apply lo nibble U=4'hA stably → frame_err=1, digits unchanged, seg never shows an undefined pattern.
- Toggle word_lo every cycle for 20 cycles, then hold 9'h023 → no update during toggling, one update after holding, digits[7:0]=23.
- Assert reset_n=0 mid-slot with an active → an, seg and dp inactive in the same cycle (async). After release, idx=0, a ghost cycle precedes every digit change, and no two an bits are ever active together.
